exec_unit: RTL and testbench

//  Execute stage directly downstream of the 8-entry register file: consumes read

---
 rtl/exec_unit.sv | 129 ++++++++++++
 tb/tb_exec_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: execute stage with single-cycle ALU, iterative multiply/divide and writeback to the register file
module exec_unit #(
  parameter int WIDTH = 8,
  parameter int REG_ADDR = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inValid,
  output logic                inReady,
  input  logic [3:0]          op,
  input  logic [REG_ADDR-1:0] rdIn,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                wrEn,
  output logic [REG_ADDR-1:0] rd,
  output logic [WIDTH-1:0]    dOut,
  output logic                zero,
  output logic                carry
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, m_q, m_d, dout_q, dout_d;
  logic [3:0] opc_q, opc_d;
  logic [REG_ADDR-1:0] dst_q, dst_d, rd_q, rd_d;
  logic wr_en_q, wr_en_d, zero_q, zero_d, carry_q, carry_d;
  logic sub;
  logic [WIDTH:0] alu_sum, mul_sum, div_sh;
  logic [WIDTH-1:0] alu_res, div_diff, fin_res;
  logic [2:0] sh;
  logic div_ge, done;
  always_comb begin
    sub = op == 4'd1;
    sh = b[2:0];
    alu_sum = {1'b0, a} + {1'b0, sub ? ~b : b} + {{WIDTH{1'b0}}, sub};
    case (op)
      4'd0, 4'd1: alu_res = alu_sum[WIDTH-1:0];
      4'd2:       alu_res = a & b;
      4'd3:       alu_res = a | b;
      4'd4:       alu_res = a ^ b;
      4'd5:       alu_res = a << sh;
      4'd6:       alu_res = a >> sh;
      default:    alu_res = WIDTH'($signed(a) >>> sh);
    endcase
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_sh = {acc_q, lo_q[WIDTH-1]};
    div_ge = div_sh >= {1'b0, m_q};
    div_diff = div_sh[WIDTH-1:0] - m_q;
    done = cnt_q == CW'(WIDTH);
    fin_res = (opc_q == 4'd8 || opc_q == 4'd10) ? lo_q : acc_q;
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    lo_d = lo_q;
    m_d = m_q;
    opc_d = opc_q;
    dst_d = dst_q;
    rd_d = rd_q;
    dout_d = dout_q;
    zero_d = zero_q;
    carry_d = carry_q;
    wr_en_d = 1'b0;
    case (state_q)
      IDLE: if (inValid && op < 4'd8) begin
        wr_en_d = 1'b1;
        rd_d = rdIn;
        dout_d = alu_res;
        zero_d = alu_res == '0;
        carry_d = op < 4'd2 ? alu_sum[WIDTH] : 1'b0;
      end else if (inValid && op < 4'd12) begin
        state_d = op < 4'd10 ? MUL : DIV;
        m_d = op < 4'd10 ? a : b;
        lo_d = op < 4'd10 ? b : a;
        acc_d = '0;
        cnt_d = '0;
        opc_d = op;
        dst_d = rdIn;
      end
      default: if (done) begin
        state_d = IDLE;
        wr_en_d = 1'b1;
        rd_d = dst_q;
        dout_d = fin_res;
        zero_d = fin_res == '0;
        carry_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = state_q == MUL ? mul_sum[WIDTH:1] : (div_ge ? div_diff : div_sh[WIDTH-1:0]);
        lo_d = state_q == MUL ? {mul_sum[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], div_ge};
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      opc_q <= '0;
      dst_q <= '0;
      rd_q <= '0;
      dout_q <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      lo_q <= lo_d;
      m_q <= m_d;
      opc_q <= opc_d;
      dst_q <= dst_d;
      rd_q <= rd_d;
      dout_q <= dout_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
      wr_en_q <= wr_en_d;
    end
  end
  assign inReady = state_q == IDLE;
  assign wrEn = wr_en_q;
  assign rd = rd_q;
  assign dOut = dout_q;
  assign zero = zero_q;
  assign carry = carry_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed self-checking bench for exec_unit
module tb_exec_unit;
  logic clk = 1'b0, rst = 1'b1, inValid = 1'b0, inReady, wrEn, zero, carry;
  logic [3:0] op = '0;
  logic [2:0] rdIn = '0, rd;
  logic [7:0] a = '0, b = '0, dOut;
  int checks = 0, failures = 0;
  exec_unit #(.WIDTH(8), .REG_ADDR(3)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .op(op), .rdIn(rdIn),
    .a(a), .b(b), .wrEn(wrEn), .rd(rd), .dOut(dOut), .zero(zero), .carry(carry)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({inReady, wrEn, rd, dOut, zero, carry} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: inReady=%b wrEn=%b rd=%0d dOut=%h zero=%b carry=%b, want 1 0 0 00 0 0", inReady, wrEn, rd, dOut, zero, carry);
    end
  endtask
  task automatic test_alu();
    logic [3:0] to [12] = '{4'd0, 4'd1, 4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd7, 4'd2};
    logic [7:0] ta [12] = '{8'hF0, 8'h05, 8'h80, 8'h03, 8'hF0, 8'hF0, 8'hAA, 8'h81, 8'h81, 8'hFF, 8'h40, 8'hF0};
    logic [7:0] tb [12] = '{8'h20, 8'h05, 8'h03, 8'h05, 8'h3C, 8'h0F, 8'hFF, 8'h01, 8'h04, 8'h01, 8'h0A, 8'h0F};
    logic [7:0] te [12] = '{8'h10, 8'h00, 8'hF0, 8'hFE, 8'h30, 8'hFF, 8'h55, 8'h02, 8'h08, 8'h00, 8'h10, 8'h00};
    logic       tc [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       tz [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      logic [2:0] r;
      r = 3'((i + 3) % 8);
      inValid = 1'b1; op = to[i]; rdIn = r; a = ta[i]; b = tb[i];
      tick();
      inValid = 1'b0;
      checks++;
      if ({wrEn, rd, dOut, carry, zero} !== {1'b1, r, te[i], tc[i], tz[i]}) begin
        failures++;
        $display("FAIL alu[%0d]: wrEn=%b rd=%0d dOut=%h carry=%b zero=%b, want 1 %0d %h %b %b", i, wrEn, rd, dOut, carry, zero, r, te[i], tc[i], tz[i]);
      end
      tick();
      checks++;
      if (wrEn !== 1'b0 || dOut !== te[i]) begin
        failures++;
        $display("FAIL alu_hold[%0d]: wrEn=%b dOut=%h, want 0 %h", i, wrEn, dOut, te[i]);
      end
    end
  endtask
  task automatic test_muldiv();
    logic [3:0] to [10] = '{4'd8, 4'd9, 4'd9, 4'd8, 4'd10, 4'd11, 4'd10, 4'd11, 4'd10, 4'd11};
    logic [7:0] ta [10] = '{8'h0D, 8'h0D, 8'hFF, 8'hFF, 8'hC8, 8'hC8, 8'h2A, 8'h2A, 8'h05, 8'h05};
    logic [7:0] tb [10] = '{8'h0B, 8'h0B, 8'hFF, 8'hFF, 8'h07, 8'h07, 8'h00, 8'h00, 8'h09, 8'h09};
    logic [7:0] te [10] = '{8'h8F, 8'h00, 8'hFE, 8'h01, 8'h1C, 8'h04, 8'hFF, 8'h2A, 8'h00, 8'h05};
    for (int i = 0; i < 10; i++) begin
      int n;
      logic busy_bad;
      n = 0;
      busy_bad = 1'b0;
      inValid = 1'b1; op = to[i]; rdIn = 3'(i); a = ta[i]; b = tb[i];
      tick();
      inValid = 1'b0;
      while (wrEn !== 1'b1 && n < 20) begin
        if (inReady !== 1'b0) busy_bad = 1'b1;
        n++;
        tick();
      end
      checks++;
      if (n != 9 || busy_bad || inReady !== 1'b1) begin
        failures++;
        $display("FAIL muldiv_latency[%0d]: busy_cycles=%0d early_ready=%b inReady=%b, want 9 0 1", i, n, busy_bad, inReady);
      end
      checks++;
      if ({rd, dOut, zero, carry} !== {3'(i), te[i], te[i] == 8'h00, 1'b0}) begin
        failures++;
        $display("FAIL muldiv[%0d]: rd=%0d dOut=%h zero=%b carry=%b, want %0d %h %b 0", i, rd, dOut, zero, carry, i, te[i], te[i] == 8'h00);
      end
    end
    tick();
  endtask
  task automatic test_busy_hold();
    int n;
    n = 0;
    inValid = 1'b1; op = 4'd10; rdIn = 3'd1; a = 8'hC8; b = 8'h07;
    tick();
    op = 4'd0; rdIn = 3'd5; a = 8'h01; b = 8'h01;
    while (wrEn !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 9 || rd !== 3'd1 || dOut !== 8'h1C) begin
      failures++;
      $display("FAIL busy_hold_div: cycles=%0d rd=%0d dOut=%h, want 9 1 1c", n, rd, dOut);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if ({wrEn, rd, dOut} !== {1'b1, 3'd5, 8'h02}) begin
      failures++;
      $display("FAIL busy_hold_add: wrEn=%b rd=%0d dOut=%h, want 1 5 02", wrEn, rd, dOut);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    inValid = 1'b1; op = 4'd10; rdIn = 3'd6; a = 8'hC8; b = 8'h07;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wrEn === 1'b1) seen = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({inReady, wrEn, rd, dOut, zero, carry} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: inReady=%b wrEn=%b rd=%0d dOut=%h zero=%b carry=%b, want 1 0 0 00 0 0", inReady, wrEn, rd, dOut, zero, carry);
    end
    for (int i = 0; i < 12; i++) begin
      if (wrEn === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid_wren: wrEn seen=1, want 0");
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] to [4] = '{4'd0, 4'd4, 4'd5, 4'd6};
    logic [7:0] ta [4] = '{8'h01, 8'h0F, 8'h01, 8'h80};
    logic [7:0] tb [4] = '{8'h02, 8'hF0, 8'h07, 8'h07};
    logic [7:0] te [4] = '{8'h03, 8'hFF, 8'h80, 8'h01};
    inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = to[i]; rdIn = 3'(i); a = ta[i]; b = tb[i];
      tick();
      checks++;
      if ({wrEn, rd, dOut} !== {1'b1, 3'(i), te[i]}) begin
        failures++;
        $display("FAIL b2b[%0d]: wrEn=%b rd=%0d dOut=%h, want 1 %0d %h", i, wrEn, rd, dOut, i, te[i]);
      end
    end
    inValid = 1'b0;
    tick();
    checks++;
    if (wrEn !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: wrEn=%b, want 0", wrEn);
    end
  endtask
  task automatic test_nop();
    inValid = 1'b1; op = 4'd13; rdIn = 3'd7; a = 8'h00; b = 8'h00;
    tick();
    inValid = 1'b0;
    checks++;
    if ({wrEn, inReady, rd, dOut, zero, carry} !== {1'b0, 1'b1, 3'd3, 8'h01, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL nop: wrEn=%b inReady=%b rd=%0d dOut=%h zero=%b carry=%b, want 0 1 3 01 0 0", wrEn, inReady, rd, dOut, zero, carry);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_alu();
    test_muldiv();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    test_nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
